// File: rtl/wsacc_pe_mc.sv
// Weight-stationary PE: NUM_OC parallel WIN-element dot products per accepted window,
// accumulated over acc_len windows, result emitted under a valid/ready handshake.
module wsacc_pe_mc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int WIN    = 9,
  parameter int NUM_OC = 4,
  parameter int LEN_W  = 16,
  localparam int OC_W  = (NUM_OC > 1) ? $clog2(NUM_OC) : 1,
  localparam int AW    = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     weight_wr_en,
  input  logic [OC_W-1:0]          weight_oc,
  input  logic [AW-1:0]            weight_addr,
  input  logic [DATA_W-1:0]        weight_i,
  input  logic [LEN_W-1:0]         acc_len,
  input  logic                     act_signed,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIN*DATA_W-1:0]    data_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OC*ACC_W-1:0]  data_o,
  output logic                     busy
);

  // Wide enough to hold any exact dot product of signed weights by 9-bit activations.
  localparam int SUM_W = 2 * DATA_W + 2 + AW;

  logic signed [DATA_W-1:0] w_q [NUM_OC][WIN];
  logic [ACC_W-1:0] dot      [NUM_OC];
  logic [ACC_W-1:0] prod_q   [NUM_OC];
  logic [ACC_W-1:0] acc_q    [NUM_OC];
  logic [ACC_W-1:0] res_q    [NUM_OC];
  logic [ACC_W-1:0] sum2     [NUM_OC];

  logic             p_valid_q, p_valid_d;
  logic             p_last_q, p_last_d;
  logic             first_q, first_d;
  logic             out_valid_q, out_valid_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             accept, adv, wr_ok, last_beat;
  logic [LEN_W-1:0] len_new, len_cur;

  assign adv       = p_valid_q && !(p_last_q && out_valid_q && !out_ready);
  assign in_ready  = !p_valid_q || adv;
  assign accept    = in_valid && in_ready;
  assign busy      = (cnt_q != '0) || p_valid_q || !first_q;
  assign out_valid = out_valid_q;

  assign wr_ok = weight_wr_en && !busy &&
                 (int'(weight_addr) < WIN) && (int'(weight_oc) < NUM_OC);

  // The group length is latched on the first beat; later beats use the latched copy.
  assign len_new   = (acc_len == '0) ? LEN_W'(1) : acc_len;
  assign len_cur   = (cnt_q == '0) ? len_new : len_q;
  assign last_beat = (cnt_q == len_cur - LEN_W'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < NUM_OC; c++)
        for (int i = 0; i < WIN; i++)
          w_q[c][i] <= '0;
    end else if (wr_ok) begin
      w_q[weight_oc][weight_addr] <= weight_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OC; gi++) begin : g_oc
      logic signed [SUM_W-1:0] sum;
      logic signed [SUM_W-1:0] w_x;
      logic signed [SUM_W-1:0] a_x;

      always_comb begin
        sum = '0;
        w_x = '0;
        a_x = '0;
        for (int i = 0; i < WIN; i++) begin
          w_x = SUM_W'(w_q[gi][i]);
          a_x = SUM_W'($signed({act_signed & data_i[i*DATA_W + DATA_W - 1],
                                data_i[i*DATA_W +: DATA_W]}));
          sum = sum + w_x * a_x;
        end
      end

      if (ACC_W > SUM_W) begin : g_ext
        assign dot[gi] = {{(ACC_W - SUM_W){sum[SUM_W-1]}}, sum};
      end else begin : g_trunc
        assign dot[gi] = sum[ACC_W-1:0];
      end

      assign sum2[gi] = first_q ? prod_q[gi] : acc_q[gi] + prod_q[gi];
      assign data_o[gi*ACC_W +: ACC_W] = res_q[gi];
    end
  endgenerate

  always_comb begin
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      p_valid_d = 1'b1;
      p_last_d  = last_beat;
      cnt_d     = last_beat ? '0 : cnt_q + LEN_W'(1);
      if (cnt_q == '0)
        len_d = len_new;
    end else if (adv) begin
      p_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    if (adv) begin
      first_d = p_last_q;
      if (p_last_q)
        out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < NUM_OC; c++) begin
        prod_q[c] <= '0;
        acc_q[c]  <= '0;
        res_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_OC; c++) begin
        if (accept)
          prod_q[c] <= dot[c];
        if (adv) begin
          if (p_last_q) begin
            res_q[c] <= sum2[c];
            acc_q[c] <= '0;
          end else begin
            acc_q[c] <= sum2[c];
          end
        end
      end
    end
  end

endmodule
